mcpu_rst_seq: RTL and testbench
===============================

# mcpu_rst_seq

Parametrised reset sequencer for the MCPU board top level. It replaces the fixed top-level reset tie-off and the unimplemented power-on counter. It holds NUM_DOMAINS downstream reset outputs asserted until the PLL reports lock, then releases them one at a time in index order (memory domain first, core last). Each release is gated on the previous domain's ready indication and a minimum gap. It also accepts a soft reset request from a button and counts those requests.

## Interface
- NUM_DOMAINS, 2: number of sequenced reset outputs; index 0 is released first; range 1–8.
- HOLD_CYCLES, 15: cycles all resets stay asserted after lock is seen; range 1–65535.
- STAGE_GAP, 4: minimum cycles between consecutive domain releases; range 1–255.
- DEBOUNCE_CYCLES, 16: stable cycles required on soft_rst_req; used only with MCPU_RST_DEBOUNCE_EN.
- clkrst_core_clk  in  1  sole clock.
- clkrst_core_rst_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock, asynchronous; synchronised internally with 2 flops.
- soft_rst_req  in  1  level-high reset request, asynchronous; 2-flop synchronised.
- dom_ready  in  NUM_DOMAINS  per-domain ready (for example mc_ready), asynchronous; 2-flop synchronised; tie high if unused.
- dom_rst_n  out  NUM_DOMAINS  active-low domain resets, registered.
- seq_done  out  1  high when every domain is released and ready.
- rst_count  out  8  number of accepted soft reset requests, saturating.

## Operation
- Reset values: dom_rst_n = 0 (all bits), seq_done = 0, rst_count = 0, state WAIT_LOCK, all synchronisers 0.
- Signal definitions:
  - req_f is the filtered soft request.
  - lock_s and rdy_s[i] are the synchronised inputs.
  - idx is the current stage index.
- WAIT_LOCK: all dom_rst_n = 0. Go to HOLD when lock_s = 1 and req_f = 0.
- HOLD: counts HOLD_CYCLES. On expiry, set dom_rst_n[0] = 1, idx = 0, go to STAGE.
- STAGE: wait until both of these hold:
  - at least STAGE_GAP cycles have passed since dom_rst_n[idx] rose;
  - rdy_s[idx] = 1.
  - Then: if idx < NUM_DOMAINS-1, set dom_rst_n[idx+1] = 1 and increment idx. Otherwise set seq_done = 1 and go to RUN.
- RUN: outputs hold; later deassertion of rdy_s has no effect.
- Abort from any state other than WAIT_LOCK: triggered by lock_s = 0 or req_f = 1.
  - Next edge: all dom_rst_n = 0, seq_done = 0, stage and hold counters cleared, state WAIT_LOCK.
  - Every abort restarts the full sequence from HOLD.
- rst_count increments on each 0→1 transition of req_f, in any state, and saturates at 255. Lock loss never increments it.
- Lock loss and a request on the same edge are a single abort; the count increments only if req_f rose on that edge.
- Released resets are monotonic within a sequence: dom_rst_n[i] = 1 implies dom_rst_n[j] = 1 for all j < i.

## Timing
Edges are counted from the first edge that samples the input at its new level.
- Lock, no request: dom_rst_n[0] rises at edge HOLD_CYCLES+3.
- dom_rst_n[i+1] rises at the later of:
  - STAGE_GAP edges after dom_rst_n[i] rose;
  - edge 3 counted from the first edge sampling dom_ready[i] = 1.
- seq_done follows the same rule, applied to the last domain.
- Lock loss: all dom_rst_n = 0 and seq_done = 0 at edge 3.
- Soft request: req_f rises at edge 2 (no debounce) or edge DEBOUNCE_CYCLES+2 (with debounce). Resets assert one edge later, and rst_count updates on that same edge.
- Request release: HOLD restarts one edge after req_f falls, provided lock_s = 1.
- Asserting clkrst_core_rst_n mid-sequence: outputs go to reset values immediately, with no clock required.

## Configuration
- MCPU_RST_DEBOUNCE_EN defined:
  - req_f changes only after the synchronised request has differed from req_f for DEBOUNCE_CYCLES consecutive cycles.
  - The difference counter clears whenever the two agree. This applies to both edges.
- Undefined: req_f equals the synchronised request, and the DEBOUNCE_CYCLES parameter is ignored.
- pll_locked and dom_ready are never debounced.

## Test plan
- Power-up, NUM_DOMAINS=2, HOLD_CYCLES=15, STAGE_GAP=4, dom_ready tied 1, pll_locked rises at edge 0 → dom_rst_n = 2'b01 at edge 18, 2'b11 at edge 22, seq_done = 1 at edge 26, rst_count = 0.
- dom_ready[0] held low until edge 40, other settings as above → dom_rst_n[1] stays 0 until edge 43, then rises; seq_done at edge 47.
- In RUN, pll_locked drops for 1 cycle at edge 100 → all dom_rst_n = 0 and seq_done = 0 at edge 103; full sequence repeats; rst_count unchanged.
- Without the macro, soft_rst_req high for edges 200–209 in RUN → resets assert and rst_count = 1 at edge 203; dom_rst_n[0] rises at edge 226. Repeat 300 times → rst_count saturates at 255.
- With MCPU_RST_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: 10-cycle glitch on soft_rst_req → no abort, rst_count = 0. 20-cycle pulse from edge 0 → abort at edge 19.
- clkrst_core_rst_n pulsed low mid-STAGE (dom_rst_n = 2'b01) → dom_rst_n = 0 asynchronously; after release, sequence timing matches scenario 1.

Source files
------------

// File: rtl/mcpu_rst_seq_if.sv
// Handshake bundle between the MCPU reset sequencer and the board top level:
// PLL lock, soft request and per-domain ready in; domain resets and status out.
interface mcpu_rst_seq_if #(
  parameter int NUM_DOMAINS = 2
);
  logic                   pll_locked;
  logic                   soft_rst_req;
  logic [NUM_DOMAINS-1:0] dom_ready;
  logic [NUM_DOMAINS-1:0] dom_rst_n;
  logic                   seq_done;
  logic [7:0]             rst_count;

  modport master (
    output pll_locked, soft_rst_req, dom_ready,
    input  dom_rst_n, seq_done, rst_count
  );

  modport slave (
    input  pll_locked, soft_rst_req, dom_ready,
    output dom_rst_n, seq_done, rst_count
  );
endinterface

// File: rtl/mcpu_rst_seq.sv
// MCPU reset sequencer: waits for PLL lock, then releases domain resets in index order.
// Define MCPU_RST_DEBOUNCE_EN to debounce the soft reset request.
//
// state     | meaning
// WAIT_LOCK | all domains in reset, waiting for lock and no soft request
// HOLD      | lock seen, counting HOLD_CYCLES before the first release
// STAGE     | domain idx released, waiting for gap and its ready
// RUN       | every domain released and ready; outputs hold
module mcpu_rst_seq #(
  parameter int NUM_DOMAINS     = 2,
  parameter int HOLD_CYCLES     = 15,
  parameter int STAGE_GAP       = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic             clkrst_core_clk,
  input logic             clkrst_core_rst_n,
  mcpu_rst_seq_if.slave   rs
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [15:0]      HOLD_LOAD = 16'(HOLD_CYCLES - 1);
  localparam logic [7:0]       GAP_LOAD  = 8'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    STAGE     = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state_q, state_nxt;
  logic [NUM_DOMAINS-1:0] dom_q, dom_nxt;
  logic                   done_q, done_nxt;
  logic [IDX_W-1:0]       idx_q, idx_nxt;
  logic [15:0]            hold_q, hold_nxt;
  logic [7:0]             gap_q, gap_nxt;

  logic                   lock_meta, lock_s;
  logic                   req_meta, req_s;
  logic [NUM_DOMAINS-1:0] rdy_meta, rdy_s;
  logic                   req_f, req_f_q;
  logic [7:0]             cnt_q;
  logic                   abort;

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      req_meta  <= 1'b0;
      req_s     <= 1'b0;
      rdy_meta  <= '0;
      rdy_s     <= '0;
    end else begin
      lock_meta <= rs.pll_locked;
      lock_s    <= lock_meta;
      req_meta  <= rs.soft_rst_req;
      req_s     <= req_meta;
      rdy_meta  <= rs.dom_ready;
      rdy_s     <= rdy_meta;
    end
  end

`ifdef MCPU_RST_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [DEB_W-1:0] deb_q;

  // req_f follows req_s only after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      deb_q <= '0;
      req_f <= 1'b0;
    end else if (req_s == req_f) begin
      deb_q <= '0;
    end else if (deb_q == DEB_LAST) begin
      deb_q <= '0;
      req_f <= req_s;
    end else begin
      deb_q <= deb_q + DEB_W'(1);
    end
  end
`else
  assign req_f = req_s;
`endif

  // Counts accepted requests only; lock loss never reaches this counter
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      req_f_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      req_f_q <= req_f;
      if (req_f && !req_f_q && (cnt_q != 8'hff))
        cnt_q <= cnt_q + 8'd1;
    end
  end

  assign abort = !lock_s || req_f;

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state_q <= WAIT_LOCK;
      dom_q   <= '0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_nxt;
      dom_q   <= dom_nxt;
      done_q  <= done_nxt;
      idx_q   <= idx_nxt;
      hold_q  <= hold_nxt;
      gap_q   <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    dom_nxt   = dom_q;
    done_nxt  = done_q;
    idx_nxt   = idx_q;
    hold_nxt  = hold_q;
    gap_nxt   = gap_q;

    if (state_q != WAIT_LOCK && abort) begin
      state_nxt = WAIT_LOCK;
      dom_nxt   = '0;
      done_nxt  = 1'b0;
      idx_nxt   = '0;
      hold_nxt  = '0;
      gap_nxt   = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          dom_nxt  = '0;
          done_nxt = 1'b0;
          if (lock_s && !req_f) begin
            state_nxt = HOLD;
            hold_nxt  = HOLD_LOAD;
          end
        end
        HOLD: begin
          if (hold_q == 16'd0) begin
            state_nxt = STAGE;
            dom_nxt   = NUM_DOMAINS'(1);
            idx_nxt   = '0;
            gap_nxt   = GAP_LOAD;
          end else begin
            hold_nxt = hold_q - 16'd1;
          end
        end
        STAGE: begin
          if (gap_q != 8'd0) begin
            gap_nxt = gap_q - 8'd1;
          end else if (rdy_s[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_nxt = RUN;
              done_nxt  = 1'b1;
            end else begin
              // thermometer shift keeps released resets monotonic in index
              dom_nxt = (dom_q << 1) | NUM_DOMAINS'(1);
              idx_nxt = idx_q + IDX_W'(1);
              gap_nxt = GAP_LOAD;
            end
          end
        end
        RUN: begin
        end
        default: begin
          state_nxt = WAIT_LOCK;
          dom_nxt   = '0;
          done_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign rs.dom_rst_n = dom_q;
  assign rs.seq_done  = done_q;
  assign rs.rst_count = cnt_q;

endmodule

// File: tb/tb_mcpu_rst_seq.sv
// Directed bench for mcpu_rst_seq: timeline tables per scenario plus hand-written
// request saturation and asynchronous reset sequences.
module tb_mcpu_rst_seq;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  mcpu_rst_seq_if #(.NUM_DOMAINS(2)) rs ();

  mcpu_rst_seq #(
    .NUM_DOMAINS    (2),
    .HOLD_CYCLES    (15),
    .STAGE_GAP      (4),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clkrst_core_clk  (clk),
    .clkrst_core_rst_n(rst_n),
    .rs               (rs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         scen;
    int         e;
    bit         chk;
    bit         drv;
    logic       lock;
    logic [1:0] rdy;
    logic       req;
    logic [1:0] dom;
    logic       done;
    int         cnt;
  } vec_t;

  vec_t vq[$];

  function automatic void add_chk(int scen, int e, logic [1:0] dom, logic done, int cnt);
    vec_t v;
    v = '{scen: scen, e: e, chk: 1'b1, drv: 1'b0, lock: 1'b0, rdy: 2'b00, req: 1'b0,
          dom: dom, done: done, cnt: cnt};
    vq.push_back(v);
  endfunction

  function automatic void add_drv(int scen, int e, logic lock, logic [1:0] rdy, logic req);
    vec_t v;
    v = '{scen: scen, e: e, chk: 1'b0, drv: 1'b1, lock: lock, rdy: rdy, req: req,
          dom: 2'b00, done: 1'b0, cnt: 0};
    vq.push_back(v);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int scen);
    int cur = 0;
    foreach (vq[i]) begin
      if (vq[i].scen == scen) begin
        while (cur < vq[i].e) begin
          step();
          cur++;
        end
        if (vq[i].chk) begin
          check($sformatf("s%0d_e%0d_dom", scen, cur), int'(rs.dom_rst_n), int'(vq[i].dom));
          check($sformatf("s%0d_e%0d_done", scen, cur), int'(rs.seq_done), int'(vq[i].done));
          check($sformatf("s%0d_e%0d_cnt", scen, cur), int'(rs.rst_count), vq[i].cnt);
        end
        if (vq[i].drv) begin
          rs.pll_locked   = vq[i].lock;
          rs.dom_ready    = vq[i].rdy;
          rs.soft_rst_req = vq[i].req;
        end
      end
    end
  endtask

  initial begin
    int n;

    // scenario 0: power-up with ready tied high
    add_drv(0, 0, 1'b1, 2'b11, 1'b0);
    add_chk(0, 2, 2'b00, 1'b0, 0);
    add_chk(0, 17, 2'b00, 1'b0, 0);
    add_chk(0, 18, 2'b01, 1'b0, 0);
    add_chk(0, 21, 2'b01, 1'b0, 0);
    add_chk(0, 22, 2'b11, 1'b0, 0);
    add_chk(0, 25, 2'b11, 1'b0, 0);
    add_chk(0, 26, 2'b11, 1'b1, 0);

    // scenario 1: late ready on domain 0, lock glitch, then soft request
    add_drv(1, 0, 1'b1, 2'b10, 1'b0);
    add_chk(1, 17, 2'b00, 1'b0, 0);
    add_chk(1, 18, 2'b01, 1'b0, 0);
    add_chk(1, 40, 2'b01, 1'b0, 0);
    add_drv(1, 40, 1'b1, 2'b11, 1'b0);
    add_chk(1, 42, 2'b01, 1'b0, 0);
    add_chk(1, 43, 2'b11, 1'b0, 0);
    add_chk(1, 46, 2'b11, 1'b0, 0);
    add_chk(1, 47, 2'b11, 1'b1, 0);
    add_chk(1, 100, 2'b11, 1'b1, 0);
    add_drv(1, 100, 1'b0, 2'b11, 1'b0);
    add_drv(1, 101, 1'b1, 2'b11, 1'b0);
    add_chk(1, 102, 2'b11, 1'b1, 0);
    add_chk(1, 103, 2'b00, 1'b0, 0);
    add_chk(1, 118, 2'b00, 1'b0, 0);
    add_chk(1, 119, 2'b01, 1'b0, 0);
    add_chk(1, 122, 2'b01, 1'b0, 0);
    add_chk(1, 123, 2'b11, 1'b0, 0);
    add_chk(1, 126, 2'b11, 1'b0, 0);
    add_chk(1, 127, 2'b11, 1'b1, 0);
`ifdef MCPU_RST_DEBOUNCE_EN
    add_drv(1, 200, 1'b1, 2'b11, 1'b1);
    add_drv(1, 210, 1'b1, 2'b11, 1'b0);
    add_chk(1, 215, 2'b11, 1'b1, 0);
    add_chk(1, 250, 2'b11, 1'b1, 0);
    add_drv(1, 300, 1'b1, 2'b11, 1'b1);
    add_chk(1, 318, 2'b11, 1'b1, 0);
    add_chk(1, 319, 2'b00, 1'b0, 1);
    add_drv(1, 320, 1'b1, 2'b11, 1'b0);
    add_chk(1, 353, 2'b00, 1'b0, 1);
    add_chk(1, 354, 2'b01, 1'b0, 1);
`else
    add_drv(1, 200, 1'b1, 2'b11, 1'b1);
    add_chk(1, 202, 2'b11, 1'b1, 0);
    add_chk(1, 203, 2'b00, 1'b0, 1);
    add_drv(1, 208, 1'b1, 2'b11, 1'b0);
    add_chk(1, 225, 2'b00, 1'b0, 1);
    add_chk(1, 226, 2'b01, 1'b0, 1);
    add_chk(1, 229, 2'b01, 1'b0, 1);
    add_chk(1, 230, 2'b11, 1'b0, 1);
    add_chk(1, 233, 2'b11, 1'b0, 1);
    add_chk(1, 234, 2'b11, 1'b1, 1);
`endif

    rst_n           = 1'b0;
    rs.pll_locked   = 1'b0;
    rs.soft_rst_req = 1'b0;
    rs.dom_ready    = 2'b11;
    #2;
    check("reset_dom", int'(rs.dom_rst_n), 0);
    check("reset_done", int'(rs.seq_done), 0);
    check("reset_cnt", int'(rs.rst_count), 0);
    step();
    rst_n = 1'b1;
    repeat (4) step();
    check("no_lock_dom", int'(rs.dom_rst_n), 0);
    apply(0);

    rst_n         = 1'b0;
    rs.pll_locked = 1'b0;
    rs.dom_ready  = 2'b10;
    step();
    rst_n = 1'b1;
    apply(1);

`ifndef MCPU_RST_DEBOUNCE_EN
    // request counter saturation: 300 short pulses on top of the one already counted
    for (int i = 0; i < 300; i++) begin
      rs.soft_rst_req = 1'b1;
      repeat (2) step();
      rs.soft_rst_req = 1'b0;
      repeat (2) step();
      if (i == 9) check("cnt_after_10", int'(rs.rst_count), 11);
    end
    repeat (4) step();
    check("cnt_saturated", int'(rs.rst_count), 255);
`endif

    // asynchronous reset while domain 0 is released and domain 1 still held
    rs.soft_rst_req = 1'b0;
    rs.pll_locked   = 1'b1;
    rs.dom_ready    = 2'b11;
    n = 0;
    while (rs.dom_rst_n != 2'b01 && n < 200) begin
      step();
      n++;
    end
    check("stage_reached", int'(n < 200), 1);
    rst_n = 1'b0;
    #2;
    check("async_dom", int'(rs.dom_rst_n), 0);
    check("async_done", int'(rs.seq_done), 0);
    check("async_cnt", int'(rs.rst_count), 0);
    step();
    check("held_dom", int'(rs.dom_rst_n), 0);
    rst_n = 1'b1;
    apply(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
